// File: rtl/mat_switch_xbar.sv
// rtl/mat_switch_xbar.sv - single-slot mailbox crossbar connecting N MatCores
module mat_switch_xbar #(
  parameter int SWITCH_WIDTH          = 16,
  parameter int SWITCH_CORE_SIZE      = 4,
  parameter int SWITCH_CORE_ADDR_SIZE = $clog2(SWITCH_CORE_SIZE),
  // Each real element travels as its IEEE-754 double bit pattern, so 0.0 is all zeros.
  parameter int ELEM_BITS             = 64
) (
  input  logic                                                          clock,
  input  logic                                                          reset,
  input  logic [SWITCH_CORE_SIZE-1:0]                                   core_send_ready,
  input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0]        core_send_core_idx,
  input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_WIDTH-1:0][ELEM_BITS-1:0]  core_send_data,
  output logic [SWITCH_CORE_SIZE-1:0]                                   core_send_ok,
  input  logic [SWITCH_CORE_SIZE-1:0]                                   core_recv_request,
  input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0]        core_recv_core_idx,
  output logic [SWITCH_CORE_SIZE-1:0]                                   core_recv_ready,
  output logic [SWITCH_CORE_SIZE-1:0][SWITCH_WIDTH-1:0][ELEM_BITS-1:0]  core_recv_data,
  output logic                                                          idle
);

  localparam int N  = SWITCH_CORE_SIZE;
  localparam int AW = SWITCH_CORE_ADDR_SIZE;
  // One extra bit so the core count itself is representable for the range check.
  localparam logic [AW:0] N_LIMIT = (AW+1)'(N);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} mbox_state_t;

  mbox_state_t                             state_q [N];
  mbox_state_t                             state_d [N];
  logic [AW-1:0]                           dest_q  [N];
  logic [SWITCH_WIDTH-1:0][ELEM_BITS-1:0]  payload_q [N];

  logic [N-1:0] accept;      // mailbox s latches an offer this edge
  logic [N-1:0] match;       // receiver d is served this edge
  logic [N-1:0] release_mb;  // mailbox s is drained this edge

  // Receiver matching: named source must be in range, full, and addressed to this receiver.
  always_comb begin
    match = '0;
    for (int d = 0; d < N; d++) begin
      if (core_recv_request[d] && !core_recv_ready[d] &&
          ({1'b0, core_recv_core_idx[d]} < N_LIMIT)) begin
        if ((state_q[core_recv_core_idx[d]] == FULL) &&
            (dest_q[core_recv_core_idx[d]] == AW'(d))) begin
          match[d] = 1'b1;
        end
      end
    end
  end

  // A mailbox drains when the receiver it is addressed to names it; dest is unique so no arbitration.
  always_comb begin
    release_mb = '0;
    for (int s = 0; s < N; s++) begin
      for (int d = 0; d < N; d++) begin
        if (match[d] && (core_recv_core_idx[d] == AW'(s))) begin
          release_mb[s] = 1'b1;
        end
      end
    end
  end

  // Mailbox next state: an offer is taken only when empty and not right after the previous accept.
  always_comb begin
    accept = '0;
    for (int s = 0; s < N; s++) begin
      state_d[s] = state_q[s];
      accept[s]  = core_send_ready[s] && (state_q[s] == EMPTY) && !core_send_ok[s];
      if (accept[s]) begin
        state_d[s] = FULL;
      end else if (release_mb[s]) begin
        state_d[s] = EMPTY;
      end
    end
  end

  // Mailbox state register; reset discards anything buffered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < N; s++) state_q[s] <= EMPTY;
    end else begin
      for (int s = 0; s < N; s++) state_q[s] <= state_d[s];
    end
  end

  // Mailbox contents are only meaningful while FULL, so they need no reset.
  always_ff @(posedge clock) begin
    for (int s = 0; s < N; s++) begin
      if (accept[s]) begin
        dest_q[s]    <= core_send_core_idx[s];
        payload_q[s] <= core_send_data[s];
      end
    end
  end

  // Handshake pulses and delivered payloads; recv data holds until the next delivery.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      core_send_ok    <= '0;
      core_recv_ready <= '0;
      core_recv_data  <= '0;
    end else begin
      core_send_ok    <= accept;
      core_recv_ready <= match;
      for (int d = 0; d < N; d++) begin
        if (match[d]) begin
          core_recv_data[d] <= payload_q[core_recv_core_idx[d]];
        end
      end
    end
  end

  // Idle whenever no mailbox holds a message.
  always_comb begin
    idle = 1'b1;
    for (int s = 0; s < N; s++) begin
      if (state_q[s] == FULL) idle = 1'b0;
    end
  end

endmodule

// File: tb/tb_mat_switch_xbar.sv
// tb/tb_mat_switch_xbar.sv - self-checking bench for mat_switch_xbar
module tb_mat_switch_xbar;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int AW = 2;
  localparam int EB = 64;

  logic                        clock = 1'b0;
  logic                        reset = 1'b0;
  logic [N-1:0]                send_ready;
  logic [N-1:0][AW-1:0]        send_idx;
  logic [N-1:0][W-1:0][EB-1:0] send_data;
  logic [N-1:0]                send_ok;
  logic [N-1:0]                recv_request;
  logic [N-1:0][AW-1:0]        recv_idx;
  logic [N-1:0]                recv_ready;
  logic [N-1:0][W-1:0][EB-1:0] recv_data;
  logic                        idle;

  int checks = 0;
  int errors = 0;

  // Reference model: mailbox contents and expected registered outputs.
  bit  m_full  [N];
  int  m_dest  [N];
  real m_pay   [N][W];
  bit  m_ok    [N];
  bit  m_rdy   [N];
  real m_rdata [N][W];

  mat_switch_xbar #(
    .SWITCH_WIDTH(W), .SWITCH_CORE_SIZE(N), .SWITCH_CORE_ADDR_SIZE(AW), .ELEM_BITS(EB)
  ) dut (
    .clock(clock), .reset(reset),
    .core_send_ready(send_ready), .core_send_core_idx(send_idx), .core_send_data(send_data),
    .core_send_ok(send_ok),
    .core_recv_request(recv_request), .core_recv_core_idx(recv_idx),
    .core_recv_ready(recv_ready), .core_recv_data(recv_data),
    .idle(idle)
  );

  always #5 clock = ~clock;

  task automatic clear_inputs();
    send_ready   = '0;
    send_idx     = '0;
    send_data    = '0;
    recv_request = '0;
    recv_idx     = '0;
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_full[c] = 0; m_dest[c] = 0; m_ok[c] = 0; m_rdy[c] = 0;
      for (int i = 0; i < W; i++) begin
        m_pay[c][i] = 0.0; m_rdata[c][i] = 0.0;
      end
    end
  endtask

  // One clock: decide transfers from the pre-edge situation, then advance; returns at the negedge.
  task automatic tick();
    bit deliver [N];
    bit take    [N];
    int src     [N];
    for (int d = 0; d < N; d++) begin
      src[d]     = int'(recv_idx[d]);
      deliver[d] = recv_request[d] && !m_rdy[d] && src[d] < N && m_full[src[d]] && m_dest[src[d]] == d;
    end
    for (int s = 0; s < N; s++) take[s] = send_ready[s] && !m_full[s] && !m_ok[s];
    @(posedge clock);
    for (int d = 0; d < N; d++) begin
      m_rdy[d] = deliver[d];
      if (deliver[d]) begin
        for (int i = 0; i < W; i++) m_rdata[d][i] = m_pay[src[d]][i];
        m_full[src[d]] = 0;
      end
    end
    for (int s = 0; s < N; s++) begin
      m_ok[s] = take[s];
      if (take[s]) begin
        m_full[s] = 1;
        m_dest[s] = int'(send_idx[s]);
        for (int i = 0; i < W; i++) m_pay[s][i] = $bitstoreal(send_data[s][i]);
      end
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    model_reset();
    #1;
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", idle); end
    checks++; if (send_ok !== 4'b0) begin errors++; $display("FAIL reset_send_ok got %b want 0000", send_ok); end
    checks++; if (recv_ready !== 4'b0) begin errors++; $display("FAIL reset_recv_ready got %b want 0000", recv_ready); end
    checks++; if (recv_data !== '0) begin errors++; $display("FAIL reset_recv_data got nonzero want all 0.0"); end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    send_ready[0] = 1'b1;
    send_idx[0]   = 2'd2;
    for (int i = 0; i < W; i++) send_data[0][i] = $realtobits(real'(i + 1));
    tick();
    checks++; if (send_ok !== 4'b0001) begin errors++; $display("FAIL basic_send_ok got %b want 0001", send_ok); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %b want 0", idle); end
    send_ready = '0;
    tick();
    checks++; if (send_ok !== 4'b0000) begin errors++; $display("FAIL basic_send_ok_single got %b want 0000", send_ok); end
    recv_request[2] = 1'b1;
    recv_idx[2]     = 2'd0;
    tick();
    checks++; if (recv_ready !== 4'b0100) begin errors++; $display("FAIL basic_recv_ready got %b want 0100", recv_ready); end
    for (int i = 0; i < W; i++) begin
      checks++;
      if (recv_data[2][i] !== $realtobits(real'(i + 1))) begin
        errors++; $display("FAIL basic_data[%0d] got %f want %f", i, $bitstoreal(recv_data[2][i]), real'(i + 1));
      end
    end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL basic_idle_back got %b want 1", idle); end
    recv_request = '0;
    tick();
    checks++; if (recv_ready !== 4'b0000) begin errors++; $display("FAIL basic_recv_pulse got %b want 0000", recv_ready); end
    checks++; if (recv_data[2][15] !== $realtobits(16.0)) begin errors++; $display("FAIL basic_data_hold got %f want 16.0", $bitstoreal(recv_data[2][15])); end
  endtask

  task automatic test_hold_and_wrong_receiver();
    int pulses = 0;
    int idle_bad = 0;
    int wrong = 0;
    send_ready[1] = 1'b1;
    send_idx[1]   = 2'd2;
    for (int i = 0; i < W; i++) send_data[1][i] = $realtobits(0.5 * real'(i) + 100.0);
    recv_request[3] = 1'b1;
    recv_idx[3]     = 2'd1;
    for (int k = 0; k < 10; k++) begin
      tick();
      pulses += int'(send_ok[1]);
      if (idle !== 1'b0) idle_bad++;
      if (recv_ready[3] !== 1'b0) wrong++;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL hold_send_ok_pulses got %0d want 1", pulses); end
    checks++; if (idle_bad != 0) begin errors++; $display("FAIL hold_idle_high got %0d cycles want 0", idle_bad); end
    checks++; if (wrong != 0) begin errors++; $display("FAIL wrong_receiver_delivered got %0d want 0", wrong); end
    send_ready = '0;
    recv_request = '0;
    recv_request[2] = 1'b1;
    recv_idx[2]     = 2'd1;
    tick();
    checks++; if (recv_ready !== 4'b0100) begin errors++; $display("FAIL right_receiver got %b want 0100", recv_ready); end
    checks++; if (recv_data[2][3] !== $realtobits(101.5)) begin errors++; $display("FAIL right_receiver_data got %f want 101.5", $bitstoreal(recv_data[2][3])); end
    recv_request = '0;
    tick();
  endtask

  task automatic test_ring();
    for (int c = 0; c < N; c++) begin
      send_ready[c]   = 1'b1;
      send_idx[c]     = AW'((c + 1) % N);
      recv_request[c] = 1'b1;
      recv_idx[c]     = AW'((c + N - 1) % N);
      for (int i = 0; i < W; i++) send_data[c][i] = $realtobits(real'(c * 100 + i));
    end
    tick();
    checks++; if (send_ok !== 4'b1111) begin errors++; $display("FAIL ring_send_ok got %b want 1111", send_ok); end
    checks++; if (recv_ready !== 4'b0000) begin errors++; $display("FAIL ring_recv_early got %b want 0000", recv_ready); end
    send_ready = '0;
    tick();
    checks++; if (recv_ready !== 4'b1111) begin errors++; $display("FAIL ring_recv_ready got %b want 1111", recv_ready); end
    for (int d = 0; d < N; d++) begin
      for (int i = 0; i < W; i++) begin
        checks++;
        if (recv_data[d][i] !== $realtobits(real'(((d + N - 1) % N) * 100 + i))) begin
          errors++; $display("FAIL ring_data[%0d][%0d] got %f want %f", d, i, $bitstoreal(recv_data[d][i]),
                              real'(((d + N - 1) % N) * 100 + i));
        end
      end
    end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL ring_idle got %b want 1", idle); end
    recv_request = '0;
    tick();
  endtask

  task automatic test_loopback();
    send_ready[0]   = 1'b1;
    send_idx[0]     = 2'd0;
    recv_request[0] = 1'b1;
    recv_idx[0]     = 2'd0;
    for (int i = 0; i < W; i++) send_data[0][i] = $realtobits(7.5);
    tick();
    checks++; if (send_ok !== 4'b0001) begin errors++; $display("FAIL loop_send_ok got %b want 0001", send_ok); end
    send_ready = '0;
    tick();
    checks++; if (recv_ready !== 4'b0001) begin errors++; $display("FAIL loop_recv_ready got %b want 0001", recv_ready); end
    for (int i = 0; i < W; i++) begin
      checks++;
      if (recv_data[0][i] !== $realtobits(7.5)) begin
        errors++; $display("FAIL loop_data[%0d] got %f want 7.5", i, $bitstoreal(recv_data[0][i]));
      end
    end
    recv_request = '0;
    tick();
  endtask

  task automatic test_reset_mid_transfer();
    int stray = 0;
    send_ready[0] = 1'b1;
    send_idx[0]   = 2'd1;
    for (int i = 0; i < W; i++) send_data[0][i] = $realtobits(3.25);
    tick();
    send_ready = '0;
    tick();
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL mid_idle_before got %b want 0", idle); end
    #2 reset = 1'b1;
    model_reset();
    #1;
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mid_idle_async got %b want 1", idle); end
    checks++; if (recv_data !== '0) begin errors++; $display("FAIL mid_recv_data_cleared got nonzero want all 0.0"); end
    @(negedge clock);
    reset = 1'b0;
    recv_request[1] = 1'b1;
    recv_idx[1]     = 2'd0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (send_ok !== 4'b0 || recv_ready !== 4'b0) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL mid_no_delivery got %0d pulsing cycles want 0", stray); end
    recv_request = '0;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] exp_ok, exp_rdy;
    bit exp_idle;
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < N; c++) begin
        send_ready[c]   = ($urandom_range(0, 2) != 0);
        send_idx[c]     = AW'($urandom_range(0, N - 1));
        recv_request[c] = ($urandom_range(0, 1) != 0);
        recv_idx[c]     = AW'($urandom_range(0, N - 1));
        for (int i = 0; i < W; i++) send_data[c][i] = $realtobits(real'($urandom_range(0, 4000)) / 8.0);
      end
      tick();
      exp_idle = 1;
      for (int c = 0; c < N; c++) begin
        exp_ok[c]  = m_ok[c];
        exp_rdy[c] = m_rdy[c];
        if (m_full[c]) exp_idle = 0;
      end
      checks++; if (send_ok !== exp_ok) begin errors++; $display("FAIL rand_send_ok cycle %0d got %b want %b", k, send_ok, exp_ok); end
      checks++; if (recv_ready !== exp_rdy) begin errors++; $display("FAIL rand_recv_ready cycle %0d got %b want %b", k, recv_ready, exp_rdy); end
      checks++; if (idle !== exp_idle) begin errors++; $display("FAIL rand_idle cycle %0d got %b want %b", k, idle, exp_idle); end
      for (int d = 0; d < N; d++) begin
        for (int i = 0; i < W; i++) begin
          checks++;
          if (recv_data[d][i] !== $realtobits(m_rdata[d][i])) begin
            errors++; $display("FAIL rand_data cycle %0d [%0d][%0d] got %f want %f", k, d, i,
                                $bitstoreal(recv_data[d][i]), m_rdata[d][i]);
          end
        end
      end
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_basic();
    test_hold_and_wrong_receiver();
    test_ring();
    test_loopback();
    test_reset_mid_transfer();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mat_switch_xbar.md
MAT_SWITCH_XBAR -- requirements
Module: mat_switch_xbar

Interface
REQ-001 Parameter SWITCH_WIDTH, default 16: number of real elements per message.
REQ-002 Parameter SWITCH_CORE_SIZE, default 4: number of attached MatCores (N).
REQ-003 Parameter SWITCH_CORE_ADDR_SIZE, default $clog2(SWITCH_CORE_SIZE): core index width (derived).
REQ-004 Port clock  input  1  single clock; all state changes on rising edge.
REQ-005 Port reset  input  1  reset is asynchronous and active-high.
REQ-006 Port core_send_ready  input  [N]  core c offers a message.
REQ-007 Port core_send_core_idx  input  [N][SWITCH_CORE_ADDR_SIZE]  destination core of core c's offer.
REQ-008 Port core_send_data  input  [N] x real[SWITCH_WIDTH]  payload of core c's offer.
REQ-009 Port core_send_ok  output  [N]  one-cycle acceptance pulse to core c.
REQ-010 Port core_recv_request  input  [N]  core c requests a message.
REQ-011 Port core_recv_core_idx  input  [N][SWITCH_CORE_ADDR_SIZE]  source core core c is waiting on.
REQ-012 Port core_recv_ready  output  [N]  one-cycle delivery pulse to core c.
REQ-013 Port core_recv_data  output  [N] x real[SWITCH_WIDTH]  delivered payload to core c.
REQ-014 Port idle  output  1  high when every mailbox is EMPTY.

Function
REQ-015 The block SHALL hold one mailbox per source core s: state (EMPTY/FULL), dest index, payload.
REQ-016 Mailbox s EMPTY -> FULL at edge when core_send_ready[s]=1, mailbox EMPTY, core_send_ok[s]=0; latches core_send_core_idx[s] and core_send_data[s].
REQ-017 core_send_ok[s] SHALL be registered, high exactly the cycle after the latching edge, low otherwise.
REQ-018 While mailbox s FULL or core_send_ok[s]=1, core_send_ready[s] SHALL be ignored (no overwrite, no double latch).
REQ-019 Match for receiver d: core_recv_request[d]=1, core_recv_ready[d]=0, mailbox s=core_recv_core_idx[d] FULL, dest[s]=d.
REQ-020 On a match edge: mailbox s -> EMPTY, core_recv_data[d] <= payload[s], core_recv_ready[d] high for exactly the next cycle.
REQ-021 core_recv_data[d] SHALL hold its value until the next delivery to d.
REQ-022 Unmatched request (mailbox EMPTY or dest mismatch) SHALL wait indefinitely, no output change.
REQ-023 Each mailbox matches at most one receiver (unique dest, unique named source); no arbitration exists.
REQ-024 A mailbox emptied at edge t SHALL accept a new offer no earlier than edge t+1 (EMPTY observed, send_ok low).
REQ-025 Loopback (dest = self) SHALL behave as any other pair.
REQ-026 Index values >= N SHALL never match; such sends latch and remain FULL until reset.
REQ-027 All N mailboxes and N receivers SHALL operate concurrently and independently in the same cycle.
REQ-028 idle SHALL be combinational AND of all mailboxes EMPTY.

Reset
REQ-029 On reset assertion, immediately: all mailboxes EMPTY, core_send_ok=0, core_recv_ready=0, core_recv_data all 0.0, idle=1.
REQ-030 Reset mid-transfer SHALL discard buffered payloads; no pulse is emitted on reset release.

Verification
REQ-031 Core0 sends [1.0..16.0] to core2, core2 requests src 0 two cycles later -> send_ok[0] at t+1, recv_ready[2] one cycle after request, data [1.0..16.0], idle returns 1.
REQ-032 Core1 holds send_ready 10 cycles, no receiver -> exactly one send_ok[1] pulse, idle=0 throughout.
REQ-033 Core3 requests src 1 while core1 sends to core2 -> no delivery to core3; core2 later requests src 1 and receives.
REQ-034 All four cores send to (c+1) mod 4 and all request (c-1) mod 4 same cycle -> four send_ok at t+1, four recv_ready at t+2, correct payloads.
REQ-035 Core0 sends to self with value 7.5 everywhere -> recv_ready[0] with all 7.5.
REQ-036 Assert reset while mailbox 0 FULL -> idle=1 immediately; later request src 0 -> no delivery.
